serial_bit_feeder: RTL and testbench
====================================

// Module: serial_bit_feeder
// PURPOSE
//  Upstream stage of the 11011 Mealy sequence detector. Accepts parallel bytes
//  through a valid/ready load port and serialises them, one bit per bit period,
//  onto the single-bit stream the detector samples.
//  A one-entry holding buffer lets back-to-back bytes stream with no idle gap.
//  Lives inside the tt_um top; the detector serial input is driven from bit_out.
// PARAMETERS
//  DATA_W   8   bits per loaded word (>=2)
//  CLK_DIV  1   clocks per bit period (>=1); 1 = one bit per clk
// PORTS
//  clk        in   1       system clock, rising edge
//  rst_n      in   1       async active-low reset
//  ena        in   1       global enable; low freezes all state
//  load_data  in   DATA_W  word to serialise
//  load_msb   in   1       1 = MSB first, 0 = LSB first; captured with the word
//  load_valid in   1       producer offers load_data
//  load_ready out  1       block can take a word this cycle
//  bit_out    out  1       serial bit to detector; 0 when idle
//  bit_valid  out  1       1-cycle strobe, first cycle of each bit period
//  busy       out  1       shift register holds an active word
//  byte_done  out  1       1-cycle pulse, last cycle of a word's final bit period
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE; shift reg, hold reg, counters cleared;
//   bit_out=0, bit_valid=0, busy=0, byte_done=0, hold empty.
//   load_ready=1 once rst_n=1 and ena=1.
//  Handshake: word accepted on an edge where load_valid && load_ready.
//   load_ready = ena && !hold_full (combinational from registers only).
//   load_data and load_msb are sampled only on acceptance.
//  FSM: IDLE, SHIFT.
//   IDLE + accept: word goes directly to the shift reg (bypasses hold); -> SHIFT.
//    Next cycle: busy=1, bit_valid=1, bit_out = first bit.
//   SHIFT + accept: word goes to the hold reg (hold_full=1).
//   SHIFT: prescaler counts 0..CLK_DIV-1; bit_out is held for CLK_DIV cycles.
//    Bit index advances when prescaler wraps.
//   Last cycle of bit DATA_W-1: byte_done=1, then:
//    hold full -> hold moves to shift reg; hold empties; stay SHIFT; no gap.
//    hold empty and accept this cycle -> accepted word loads shift reg; no gap.
//    otherwise -> IDLE; bit_out=0, busy=0 next cycle.
//   Transfer and new accept never coincide: load_ready=0 while hold is full.
//  Bit order: MSB first emits data[DATA_W-1]..data[0]; LSB first emits the reverse.
//   Order is fixed per word by its captured load_msb.
//  Prescaler is cleared to 0 on every word start.
//   With CLK_DIV=1, bit_valid stays high for the whole word.
//  ena=0: prescaler, bit index, FSM and hold freeze; outputs hold their values,
//   except bit_valid=0 and byte_done=0. Resumes in place when ena returns to 1.
//  rst_n low mid-word: word and held word are discarded; outputs go to reset
//   values immediately.
//  Latency: accept edge -> first bit 1 cycle; word spans DATA_W*CLK_DIV cycles.
// STRUCTURE
//  Package serial_feeder_pkg holds:
//   state enum {IDLE, SHIFT}; DATA_W/CLK_DIV defaults;
//   localparams CNT_W = clog2(CLK_DIV) (min 1) and IDX_W = clog2(DATA_W).
//  Sub-module bit_period_prescaler: clear/enable in, tick out, CLK_DIV param.
//   Instantiated once; FSM, shift reg and hold reg stay in this module.
// TESTING
//  1 CLK_DIV=1; load 8'b11011000, msb=1 -> bit_out 1,1,0,1,1,0,0,0 on cycles 1..8.
//    byte_done on cycle 8; downstream detector pulses exactly once.
//  2 CLK_DIV=1; load 8'h1B, msb=0 -> bit_out 1,1,0,1,1,0,0,0 (LSB first).
//    busy drops on cycle 9.
//  3 CLK_DIV=1; load A then B on the next cycle -> load_ready=0 while B is held.
//    B bit0 follows A bit7 with no gap; 16 consecutive bit_valid.
//  4 CLK_DIV=3; load 8'hFF -> each bit held 3 cycles; bit_valid every 3rd cycle.
//    byte_done at cycle 24.
//  5 Hold empty; assert load_valid exactly on A's last bit cycle -> seamless start.
//  6 Reset asserted mid-word (bit 4); ena dropped for 5 cycles mid-word ->
//    reset: outputs cleared at once, load_ready=1 after release.
//    ena: word stretches by exactly 5 cycles, bit sequence intact.

Source files
------------

// File: rtl/serial_feeder_pkg.sv
// Shared types and sizing helpers for the serial bit feeder that drives the 11011 detector.
package serial_feeder_pkg;

    localparam int unsigned DATA_W_DEF  = 8;
    localparam int unsigned CLK_DIV_DEF = 1;

    typedef logic [0:0] state_t;
    localparam state_t IDLE  = 1'b0;
    localparam state_t SHIFT = 1'b1;

    // Counter width that never collapses to zero bits for a divide-by-one prescaler.
    function automatic int unsigned clog2_min1(int unsigned v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

    localparam int unsigned CNT_W = clog2_min1(CLK_DIV_DEF);
    localparam int unsigned IDX_W = $clog2(DATA_W_DEF);

endpackage

// File: rtl/serial_bit_feeder_if.sv
// Load handshake plus serial output bundle between a byte producer and the feeder.
interface serial_bit_feeder_if
    import serial_feeder_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
);
    logic [DATA_W-1:0] load_data;
    logic              load_msb;
    logic              load_valid;
    logic              load_ready;
    logic              bit_out;
    logic              bit_valid;
    logic              busy;
    logic              byte_done;

    modport master (
        output load_data, load_msb, load_valid,
        input  load_ready, bit_out, bit_valid, busy, byte_done
    );

    modport slave (
        input  load_data, load_msb, load_valid,
        output load_ready, bit_out, bit_valid, busy, byte_done
    );
endinterface

// File: rtl/bit_period_prescaler.sv
// Counts clocks within one bit period; tick marks the last cycle, period_start the first.
module bit_period_prescaler
    import serial_feeder_pkg::*;
#(
    parameter int unsigned CLK_DIV = CLK_DIV_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tick,
    output logic period_start
);
    localparam int unsigned W_CNT = clog2_min1(CLK_DIV);
    localparam logic [W_CNT-1:0] CNT_LAST = W_CNT'(CLK_DIV - 1);

    logic [W_CNT-1:0] cnt_q;

    assign tick         = enable && (cnt_q == CNT_LAST);
    assign period_start = (cnt_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= tick ? '0 : cnt_q + 1'b1;
        end
    end
endmodule

// File: rtl/serial_bit_feeder.sv
// Serialises loaded words onto bit_out; a one-entry hold buffer keeps back-to-back words gapless.
module serial_bit_feeder
    import serial_feeder_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned CLK_DIV = CLK_DIV_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    serial_bit_feeder_if.slave bus
);
    localparam int unsigned W_IDX = $clog2(DATA_W);
    localparam logic [W_IDX-1:0] IDX_LAST = W_IDX'(DATA_W - 1);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              msb_q, msb_d;
    logic [W_IDX-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              hold_msb_q, hold_msb_d;
    logic              hold_full_q, hold_full_d;

    logic accept;
    logic run;
    logic start;
    logic tick;
    logic period_start;
    logic last_bit;

    assign bus.load_ready = ena && !hold_full_q;
    assign accept         = bus.load_valid && bus.load_ready;
    assign run            = ena && (state_q == SHIFT);
    assign last_bit       = tick && (idx_q == IDX_LAST);

    bit_period_prescaler #(
        .CLK_DIV (CLK_DIV)
    ) u_prescaler (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (start),
        .enable       (run),
        .tick         (tick),
        .period_start (period_start)
    );

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        msb_d       = msb_q;
        idx_d       = idx_q;
        hold_d      = hold_q;
        hold_msb_d  = hold_msb_q;
        hold_full_d = hold_full_q;
        start       = 1'b0;

        if (ena) begin
            if (state_q == IDLE) begin
                // An idle feeder bypasses the hold buffer so the first bit appears next cycle.
                if (accept) begin
                    shreg_d = bus.load_data;
                    msb_d   = bus.load_msb;
                    idx_d   = '0;
                    state_d = SHIFT;
                    start   = 1'b1;
                end
            end else if (last_bit) begin
                idx_d = '0;
                if (hold_full_q) begin
                    shreg_d     = hold_q;
                    msb_d       = hold_msb_q;
                    hold_full_d = 1'b0;
                    start       = 1'b1;
                end else if (accept) begin
                    shreg_d = bus.load_data;
                    msb_d   = bus.load_msb;
                    start   = 1'b1;
                end else begin
                    shreg_d = '0;
                    state_d = IDLE;
                end
            end else begin
                if (tick) begin
                    shreg_d = msb_q ? (shreg_q << 1) : (shreg_q >> 1);
                    idx_d   = idx_q + 1'b1;
                end
                if (accept) begin
                    hold_d      = bus.load_data;
                    hold_msb_d  = bus.load_msb;
                    hold_full_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            msb_q       <= 1'b0;
            idx_q       <= '0;
            hold_q      <= '0;
            hold_msb_q  <= 1'b0;
            hold_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            msb_q       <= msb_d;
            idx_q       <= idx_d;
            hold_q      <= hold_d;
            hold_msb_q  <= hold_msb_d;
            hold_full_q <= hold_full_d;
        end
    end

    // The outgoing bit always sits at the end of the shift register facing the chosen order.
    assign bus.bit_out   = (state_q == SHIFT) && (msb_q ? shreg_q[DATA_W-1] : shreg_q[0]);
    assign bus.bit_valid = run && period_start;
    assign bus.busy      = (state_q == SHIFT);
    assign bus.byte_done = last_bit;
endmodule

// File: tb/tb_serial_bit_feeder.sv
// Bench for serial_bit_feeder: CLK_DIV=1 and CLK_DIV=3 instances against a bit-schedule queue model.
module tb_serial_bit_feeder;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ena = 1'b0;
    always #5 clk = ~clk;

    serial_bit_feeder_if #(.DATA_W(W)) b1 ();
    serial_bit_feeder_if #(.DATA_W(W)) b3 ();

    serial_bit_feeder #(.DATA_W(W), .CLK_DIV(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .bus   (b1)
    );
    serial_bit_feeder #(.DATA_W(W), .CLK_DIV(3)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .bus   (b3)
    );

    logic         vld [2];
    logic [W-1:0] dat [2];
    logic         msb [2];
    assign b1.load_valid = vld[0];
    assign b1.load_data  = dat[0];
    assign b1.load_msb   = msb[0];
    assign b3.load_valid = vld[1];
    assign b3.load_data  = dat[1];
    assign b3.load_msb   = msb[1];

    logic o_bit [2], o_bv [2], o_bd [2], o_busy [2], o_rdy [2];
    assign o_bit[0]  = b1.bit_out;
    assign o_bv[0]   = b1.bit_valid;
    assign o_bd[0]   = b1.byte_done;
    assign o_busy[0] = b1.busy;
    assign o_rdy[0]  = b1.load_ready;
    assign o_bit[1]  = b3.bit_out;
    assign o_bv[1]   = b3.bit_valid;
    assign o_bd[1]   = b3.byte_done;
    assign o_busy[1] = b3.busy;
    assign o_rdy[1]  = b3.load_ready;

    // Model: one entry per future clock cycle of serial output, in emission order.
    typedef struct packed {
        logic b;
        logic first;
        logic last;
    } ent_t;
    ent_t mq [2][$];

    typedef struct {
        logic         vld;
        logic [W-1:0] dat;
        logic         msb;
        logic         e_bit, e_bv, e_bd, e_busy, e_rdy;
    } vec_t;
    vec_t tbl [20];

    int total = 0;
    int bad = 0;
    logic s_bit [2], s_bv [2], s_bd [2], s_busy [2], s_rdy [2];
    logic [4:0] det_sr = '0;
    int det_cnt = 0;

    function automatic int div_of(int i);
        return (i == 0) ? 1 : 3;
    endfunction

    task automatic chk(string nm, int act, int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic push_word(int i, logic [W-1:0] d, logic m);
        ent_t e;
        logic bv;
        for (int b = 0; b < W; b++) begin
            bv = m ? d[W-1-b] : d[b];
            for (int c = 0; c < div_of(i); c++) begin
                e.b     = bv;
                e.first = (c == 0);
                e.last  = (b == W - 1) && (c == div_of(i) - 1);
                mq[i].push_back(e);
            end
        end
    endtask

    task automatic check_dut(int i);
        logic eb, ebusy, ebv, ebd, er;
        ent_t e;
        er = ena && (mq[i].size() <= W * div_of(i));
        if (mq[i].size() == 0) begin
            eb = 0; ebusy = 0; ebv = 0; ebd = 0;
        end else begin
            e = mq[i][0];
            eb = e.b; ebusy = 1; ebv = ena && e.first; ebd = ena && e.last;
        end
        chk($sformatf("d%0d bit_out", i), o_bit[i], eb);
        chk($sformatf("d%0d busy", i), o_busy[i], ebusy);
        chk($sformatf("d%0d bit_valid", i), o_bv[i], ebv);
        chk($sformatf("d%0d byte_done", i), o_bd[i], ebd);
        chk($sformatf("d%0d load_ready", i), o_rdy[i], er);
    endtask

    // Check at negedge with the current inputs, then advance the model across the posedge.
    task automatic cycle();
        logic         acc [2];
        logic [W-1:0] ad [2];
        logic         am [2];
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            s_bit[i] = o_bit[i]; s_bv[i] = o_bv[i]; s_bd[i] = o_bd[i];
            s_busy[i] = o_busy[i]; s_rdy[i] = o_rdy[i];
            check_dut(i);
            acc[i] = vld[i] && ena && (mq[i].size() <= W * div_of(i));
            ad[i] = dat[i];
            am[i] = msb[i];
        end
        if (s_bv[0]) begin
            det_sr = {det_sr[3:0], s_bit[0]};
            if (det_sr == 5'b11011) det_cnt++;
        end
        @(posedge clk);
        if (ena) begin
            for (int i = 0; i < 2; i++) begin
                if (mq[i].size() > 0) void'(mq[i].pop_front());
                if (acc[i]) push_word(i, ad[i], am[i]);
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        for (int i = 0; i < 2; i++) begin
            vld[i] = 0; dat[i] = '0; msb[i] = 0;
        end
    endtask

    initial begin
        logic [7:0] pat;
        int n_bv, n_rdy0, nbd, bdc, misplaced, ones;

        idle_inputs();
        pat = 8'b11011000;
        for (int k = 0; k < 2; k++) begin
            tbl[k*10] = '{1'b1, (k == 0) ? 8'hD8 : 8'h1B, (k == 0), 0, 0, 0, 0, 1};
            for (int j = 1; j <= 8; j++)
                tbl[k*10+j] = '{1'b0, 8'h00, 1'b0, pat[8-j], 1, (j == 8), 1, 1};
            tbl[k*10+9] = '{1'b0, 8'h00, 1'b0, 0, 0, 0, 0, 1};
        end

        // Reset state
        @(posedge clk); #1;
        @(negedge clk);
        check_dut(0);
        check_dut(1);
        @(posedge clk); #1;
        ena = 1; rst_n = 1; #1;
        chk("ready after reset d1", o_rdy[0], 1);
        chk("ready after reset d3", o_rdy[1], 1);

        // Tests 1 and 2: directed table on the CLK_DIV=1 instance
        det_sr = '0; det_cnt = 0;
        for (int r = 0; r < 20; r++) begin
            vld[0] = tbl[r].vld; dat[0] = tbl[r].dat; msb[0] = tbl[r].msb;
            cycle();
            chk($sformatf("tbl%0d bit_out", r), s_bit[0], tbl[r].e_bit);
            chk($sformatf("tbl%0d bit_valid", r), s_bv[0], tbl[r].e_bv);
            chk($sformatf("tbl%0d byte_done", r), s_bd[0], tbl[r].e_bd);
            chk($sformatf("tbl%0d busy", r), s_busy[0], tbl[r].e_busy);
            chk($sformatf("tbl%0d load_ready", r), s_rdy[0], tbl[r].e_rdy);
            if (r == 9) begin
                chk("detector hits", det_cnt, 1);
                det_cnt = 0; det_sr = '0;
            end
        end

        // Test 3: back-to-back words, second one waits in the hold buffer
        vld[0] = 1; dat[0] = 8'hA5; msb[0] = 1;
        cycle();
        dat[0] = 8'h3C; msb[0] = 0;
        cycle();
        vld[0] = 0;
        n_bv = s_bv[0]; n_rdy0 = 0;
        for (int c = 2; c <= 17; c++) begin
            cycle();
            n_bv += s_bv[0];
            n_rdy0 += !s_rdy[0];
        end
        chk("b2b bit_valid count", n_bv, 16);
        chk("b2b ready low cycles", n_rdy0, 7);

        // Test 4: CLK_DIV=3, each bit held three cycles
        vld[1] = 1; dat[1] = 8'hFF; msb[1] = 1;
        cycle();
        idle_inputs();
        n_bv = 0; misplaced = 0; nbd = 0; bdc = 0; ones = 0;
        for (int c = 1; c <= 25; c++) begin
            cycle();
            if (s_bv[1]) begin
                n_bv++;
                if (c % 3 != 1) misplaced++;
            end
            if (s_bd[1]) begin nbd++; bdc = c; end
            if (s_bit[1]) ones++;
        end
        chk("div3 bit_valid count", n_bv, 8);
        chk("div3 bit_valid misplaced", misplaced, 0);
        chk("div3 byte_done count", nbd, 1);
        chk("div3 byte_done cycle", bdc, 24);
        chk("div3 bit_out high cycles", ones, 24);

        // Test 5: new word offered exactly on the last bit cycle
        vld[0] = 1; dat[0] = 8'h96; msb[0] = 1;
        cycle();
        n_bv = 0;
        for (int c = 1; c <= 16; c++) begin
            vld[0] = (c == 8); dat[0] = 8'h5A; msb[0] = 0;
            cycle();
            n_bv += s_bv[0];
        end
        vld[0] = 0;
        cycle();
        chk("seamless bit_valid count", n_bv, 16);
        chk("seamless idle busy", s_busy[0], 0);

        // Test 6a: reset in the middle of a word
        for (int i = 0; i < 2; i++) begin
            vld[i] = 1; dat[i] = 8'hFF; msb[i] = 1;
        end
        cycle();
        idle_inputs();
        for (int c = 1; c <= 4; c++) cycle();
        rst_n = 0; #2;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst d%0d bit_out", i), o_bit[i], 0);
            chk($sformatf("rst d%0d busy", i), o_busy[i], 0);
            chk($sformatf("rst d%0d bit_valid", i), o_bv[i], 0);
            chk($sformatf("rst d%0d byte_done", i), o_bd[i], 0);
            mq[i].delete();
        end
        @(posedge clk); #1;
        rst_n = 1; #1;
        chk("rst release ready d1", o_rdy[0], 1);
        chk("rst release ready d3", o_rdy[1], 1);
        cycle();

        // Test 6b: ena low for five cycles mid-word
        vld[0] = 1; dat[0] = 8'hB2; msb[0] = 1;
        cycle();
        vld[0] = 0;
        bdc = 0;
        for (int c = 1; c <= 30; c++) begin
            ena = !(c >= 4 && c <= 8);
            cycle();
            if (s_bd[0] && bdc == 0) bdc = c;
        end
        ena = 1;
        chk("ena stall byte_done cycle", bdc, 13);

        // Randomised traffic against the model
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 2; i++) begin
                vld[i] = ($urandom_range(0, 3) != 0);
                dat[i] = W'($urandom);
                msb[i] = $urandom_range(0, 1) != 0;
            end
            ena = ($urandom_range(0, 9) != 0);
            cycle();
        end
        idle_inputs();
        ena = 1;
        for (int c = 0; c < 30; c++) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
